// File: rtl/mem_writeback.sv
// Memory/write-back stage: accepts one executed instruction, performs the
// ld/str data access over req/ack, then commits in a single write-back cycle.
module mem_writeback #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  rd_num,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] md,
  input  logic [DATA_W-1:0] cpsr_in,
  input  logic              taken,
  input  logic              is_alu_op,
  input  logic              is_cmp_op,
  input  logic              is_jmp_op,
  input  logic              is_ld_op,
  input  logic              is_str_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              reg_we,
  output logic [REG_W-1:0]  reg_wnum,
  output logic [DATA_W-1:0] reg_wval,
  output logic              cpsr_we,
  output logic [DATA_W-1:0] cpsr_wval,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wval,
  output logic              retired,
  output logic              mem_err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ld_q, ld_d;
  logic              str_q, str_d;
  logic [REG_W-1:0]  rd_num_q, rd_num_d;
  logic [DATA_W-1:0] rd_val_q, rd_val_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_W-1:0]  reg_wnum_q, reg_wnum_d;
  logic [DATA_W-1:0] reg_wval_q, reg_wval_d;
  logic              cpsr_we_q, cpsr_we_d;
  logic [DATA_W-1:0] cpsr_wval_q, cpsr_wval_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_wval_q, pc_wval_d;
  logic              retired_q, retired_d;
  logic              mem_err_q, mem_err_d;

  // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so execute must hold the bundle until then.
  assign in_ready    = (state_q == IDLE);
  assign mem_req     = (state_q == MEM);
  assign mem_we      = str_q;
  assign mem_addr    = md_q;
  assign mem_wdata   = rd_val_q;
  assign reg_we      = reg_we_q;
  assign reg_wnum    = reg_wnum_q;
  assign reg_wval    = reg_wval_q;
  assign cpsr_we     = cpsr_we_q;
  assign cpsr_wval   = cpsr_wval_q;
  assign pc_we       = pc_we_q;
  assign pc_wval     = pc_wval_q;
  assign retired     = retired_q;
  assign mem_err     = mem_err_q;
  assign dbg_state_o = state_q;

  // Commit outputs are registered on the edge that enters WB, so each strobe
  // is visible for exactly the WB cycle and data outputs hold otherwise.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    str_d       = str_q;
    rd_num_d    = rd_num_q;
    rd_val_d    = rd_val_q;
    md_d        = md_q;
    reg_we_d    = 1'b0;
    reg_wnum_d  = reg_wnum_q;
    reg_wval_d  = reg_wval_q;
    cpsr_we_d   = 1'b0;
    cpsr_wval_d = cpsr_wval_q;
    pc_we_d     = 1'b0;
    pc_wval_d   = pc_wval_q;
    retired_d   = 1'b0;
    mem_err_d   = mem_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ld_d     = is_ld_op;
          str_d    = is_str_op & ~is_ld_op;
          rd_num_d = rd_num;
          rd_val_d = rd_val;
          md_d     = md;
          cnt_d    = 8'd0;
          if (is_ld_op || is_str_op) begin
            state_d = MEM;
          end else begin
            state_d   = WB;
            retired_d = 1'b1;
            if (is_alu_op) begin
              reg_we_d   = 1'b1;
              reg_wnum_d = rd_num;
              reg_wval_d = result;
            end else if (is_cmp_op) begin
              cpsr_we_d   = 1'b1;
              cpsr_wval_d = cpsr_in;
            end else if (is_jmp_op && taken) begin
              pc_we_d   = 1'b1;
              pc_wval_d = md;
            end
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d   = WB;
          retired_d = 1'b1;
          if (ld_q) begin
            reg_we_d   = 1'b1;
            reg_wnum_d = rd_num_q;
            reg_wval_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = WB;
          retired_d = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      str_q       <= 1'b0;
      rd_num_q    <= '0;
      rd_val_q    <= '0;
      md_q        <= '0;
      reg_we_q    <= 1'b0;
      reg_wnum_q  <= '0;
      reg_wval_q  <= '0;
      cpsr_we_q   <= 1'b0;
      cpsr_wval_q <= '0;
      pc_we_q     <= 1'b0;
      pc_wval_q   <= '0;
      retired_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      str_q       <= str_d;
      rd_num_q    <= rd_num_d;
      rd_val_q    <= rd_val_d;
      md_q        <= md_d;
      reg_we_q    <= reg_we_d;
      reg_wnum_q  <= reg_wnum_d;
      reg_wval_q  <= reg_wval_d;
      cpsr_we_q   <= cpsr_we_d;
      cpsr_wval_q <= cpsr_wval_d;
      pc_we_q     <= pc_we_d;
      pc_wval_q   <= pc_wval_d;
      retired_q   <= retired_d;
      mem_err_q   <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: linear sequence of hand-computed vectors,
// outputs sampled 1 time unit after each rising edge.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rd_num;
  logic [31:0] rd_val, result, md, cpsr_in;
  logic        taken, is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        reg_we;
  logic [3:0]  reg_wnum;
  logic [31:0] reg_wval;
  logic        cpsr_we;
  logic [31:0] cpsr_wval;
  logic        pc_we;
  logic [31:0] pc_wval;
  logic        retired, mem_err;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_writeback #(.DATA_W(32), .REG_W(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd_num(rd_num), .rd_val(rd_val), .result(result), .md(md),
    .cpsr_in(cpsr_in), .taken(taken), .is_alu_op(is_alu_op),
    .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op), .is_ld_op(is_ld_op),
    .is_str_op(is_str_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .reg_we(reg_we), .reg_wnum(reg_wnum),
    .reg_wval(reg_wval), .cpsr_we(cpsr_we), .cpsr_wval(cpsr_wval),
    .pc_we(pc_we), .pc_wval(pc_wval), .retired(retired), .mem_err(mem_err),
    .dbg_state_o(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid  = 1'b0;
    is_alu_op = 1'b0;
    is_cmp_op = 1'b0;
    is_jmp_op = 1'b0;
    is_ld_op  = 1'b0;
    is_str_op = 1'b0;
    taken     = 1'b0;
  endtask

  task automatic chk_strobes(input string tag, input logic r, input logic c, input logic p,
                             input logic ret);
    chk({tag, "_reg_we"}, 32'(reg_we), 32'(r));
    chk({tag, "_cpsr_we"}, 32'(cpsr_we), 32'(c));
    chk({tag, "_pc_we"}, 32'(pc_we), 32'(p));
    chk({tag, "_retired"}, 32'(retired), 32'(ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear_in();
    rd_num = '0; rd_val = '0; result = '0; md = '0; cpsr_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_reg_wval", reg_wval, 32'd0);
    chk_strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // ALU op
    in_valid = 1'b1; is_alu_op = 1'b1; rd_num = 4'd3; result = 32'h0000_00A5;
    tick(); clear_in();
    chk_strobes("alu_wb", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("alu_wnum", 32'(reg_wnum), 32'd3);
    chk("alu_wval", reg_wval, 32'h0000_00A5);
    chk("alu_wb_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_strobes("alu_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_after_in_ready", 32'(in_ready), 32'd1);
    chk("alu_wval_hold", reg_wval, 32'h0000_00A5);

    // Load, ack three cycles after the request appears
    in_valid = 1'b1; is_ld_op = 1'b1; md = 32'h0000_0040; rd_num = 4'd7;
    tick(); clear_in(); md = 32'h0000_0999; rd_num = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_mem_addr", mem_addr, 32'h0000_0040);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      chk("ld_in_ready", 32'(in_ready), 32'd0);
      chk("ld_reg_we", 32'(reg_we), 32'd0);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_wb_mem_req", 32'(mem_req), 32'd0);
    chk_strobes("ld_wb", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ld_wnum", 32'(reg_wnum), 32'd7);
    chk("ld_wval", reg_wval, 32'hDEAD_BEEF);
    tick();
    chk_strobes("ld_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_after_in_ready", 32'(in_ready), 32'd1);

    // Store with lower-priority alu/cmp flags also set; ack held from accept
    in_valid = 1'b1; is_str_op = 1'b1; is_alu_op = 1'b1; is_cmp_op = 1'b1;
    md = 32'hFFFF_FFF0; rd_val = 32'h1234_5678; result = 32'h99; cpsr_in = 32'hF;
    mem_ack = 1'b1;
    tick(); clear_in();
    chk("st_mem_req", 32'(mem_req), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", mem_addr, 32'hFFFF_FFF0);
    chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
    chk_strobes("st_mem", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("st_wb_mem_req", 32'(mem_req), 32'd0);
    chk_strobes("st_wb", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); mem_ack = 1'b0;
    chk_strobes("st_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("st_wval_hold", reg_wval, 32'hDEAD_BEEF);

    // Compare (jmp flag also set, must lose)
    in_valid = 1'b1; is_cmp_op = 1'b1; is_jmp_op = 1'b1; taken = 1'b1;
    cpsr_in = 32'h4; md = 32'h200;
    tick(); clear_in();
    chk_strobes("cmp_wb", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cmp_wval", cpsr_wval, 32'h4);
    tick();

    // Jump taken
    in_valid = 1'b1; is_jmp_op = 1'b1; taken = 1'b1; md = 32'h100;
    tick(); clear_in();
    chk_strobes("jmp_t_wb", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("jmp_t_wval", pc_wval, 32'h100);
    tick();

    // Jump not taken
    in_valid = 1'b1; is_jmp_op = 1'b1; taken = 1'b0; md = 32'h300;
    tick(); clear_in();
    chk_strobes("jmp_nt_wb", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jmp_nt_wval_hold", pc_wval, 32'h100);
    tick();

    // Nop: no class flag
    in_valid = 1'b1;
    tick(); clear_in();
    chk_strobes("nop_wb", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("nop_cpsr_hold", cpsr_wval, 32'h4);
    tick();

    // Load that never gets acked
    in_valid = 1'b1; is_ld_op = 1'b1; md = 32'h80; rd_num = 4'd9;
    tick(); clear_in();
    for (int i = 0; i < 15; i++) begin
      chk("to_mem_req", 32'(mem_req), 32'd1);
      chk("to_mem_err_pre", 32'(mem_err), 32'd0);
      tick();
    end
    chk("to_wb_mem_req", 32'(mem_req), 32'd0);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk_strobes("to_wb", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_strobes("to_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_after_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; is_alu_op = 1'b1; rd_num = 4'd2; result = 32'h55;
    tick(); clear_in();
    chk_strobes("to_alu_wb", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("to_alu_wval", reg_wval, 32'h55);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    tick();

    // Reset during an outstanding load; late ack must be ignored
    in_valid = 1'b1; is_ld_op = 1'b1; md = 32'h44; rd_num = 4'd5;
    tick(); clear_in();
    chk("rm_mem_req", 32'(mem_req), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_mem_req_after", 32'(mem_req), 32'd0);
    chk("rm_mem_err_after", 32'(mem_err), 32'd0);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    chk("rm_mem_addr", mem_addr, 32'd0);
    chk("rm_reg_wval", reg_wval, 32'd0);
    chk_strobes("rm_after", 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk_strobes("rm_late_ack", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_late_in_ready", 32'(in_ready), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk_strobes("rm_late_ack2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_late_mem_req", 32'(mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Consumer end of the execute stage's output bundle: accepts one executed instruction at a time (ALU result, compare flags, branch decision, ld/str controls).
- Performs the data-memory access for ld/str over a req/ack handshake.
- Commits the architectural effect in a single write-back cycle: register file write, CPSR write, or PC redirect.
- Back-pressures execute through a valid/ready pair while a memory access is outstanding.

Parameters:
- DATA_W, 32, width of data, address and CPSR/PC values.
- REG_W, 4, register-number width.
- ACK_TIMEOUT, 15, max cycles in MEM without mem_ack before abort (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  block can accept a bundle
- rd_num  in  REG_W  destination register (alu/ld)
- rd_val  in  DATA_W  store data (str)
- result  in  DATA_W  ALU result
- md  in  DATA_W  sign-extended memory address (ld/str) or jump target
- cpsr_in  in  DATA_W  compare result {28'd0,nzcv}
- taken  in  1  branch condition satisfied
- is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op  in  1 each  instruction class flags
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completion
- reg_we  out  1  register write strobe
- reg_wnum  out  REG_W  register number
- reg_wval  out  DATA_W  register data
- cpsr_we  out  1  CPSR write strobe
- cpsr_wval  out  DATA_W  CPSR data
- pc_we  out  1  PC redirect strobe
- pc_wval  out  DATA_W  redirect target
- retired  out  1  one-cycle pulse per completed instruction
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low. rst_n low at a rising edge forces state IDLE, clears the timeout counter, and sets every registered output to 0, including mem_err. Any pending memory request is dropped with no write-back.
- FSM states: IDLE, MEM, WB. in_ready = (state==IDLE), so it is 1 the first cycle after reset is released.
- IDLE: on in_valid & in_ready, latch the whole bundle.
  - ld or str class -> MEM.
  - Otherwise -> WB.
  - in_valid low -> stay in IDLE.
- Class priority (if several flags are set): ld > str > alu > cmp > jmp; lower-priority flags are ignored. No flag set = nop: goes through WB with no strobes but still pulses retired.
- MEM:
  - mem_req=1 from the first MEM cycle.
  - mem_addr=latched md, mem_we=str, mem_wdata=latched rd_val; all held stable until the cycle mem_ack is sampled high.
  - On mem_ack: ld captures mem_rdata -> WB; mem_req drops the next cycle.
  - Counter increments each MEM cycle without ack. At ACK_TIMEOUT: drop mem_req, set mem_err=1 (sticky until reset), go to WB with the ld register write suppressed.
  - mem_ack in IDLE/WB is ignored.
- WB (exactly one cycle; all strobes are single-cycle pulses):
  - alu: reg_we=1, reg_wnum=rd_num, reg_wval=result.
  - ld (acked): reg_we=1, reg_wnum=rd_num, reg_wval=captured data.
  - cmp: cpsr_we=1, cpsr_wval=cpsr_in.
  - jmp & taken: pc_we=1, pc_wval=md. jmp & !taken: no strobe.
  - str: no strobe.
  - retired=1. Next state IDLE.
- Data outputs (reg_wnum/reg_wval/cpsr_wval/pc_wval) hold their last value when their strobe is low.
- Latency:
  - Non-memory op accepted at edge N: strobe visible in cycle N+1; in_ready returns in cycle N+2.
  - Memory op accepted at edge N: mem_req visible in cycle N+1. If ack is sampled at edge N+k, WB is in cycle N+k+1.
- Throughput: at most one instruction per 2 cycles; no pipelining inside the block.

Test Plan:
- ALU: is_alu_op=1, rd_num=3, result=0x0000_00A5 -> exactly one reg_we pulse with wnum=3, wval=0xA5 in the cycle after accept; retired pulses in the same cycle; in_ready high in the following cycle.
- Load: is_ld_op=1, md=0x0000_0040, rd_num=7; memory acks 3 cycles after req with rdata=0xDEAD_BEEF -> mem_req/mem_addr=0x40/mem_we=0 stable until ack; reg_we with wnum=7, wval=0xDEADBEEF one cycle after ack; in_ready low throughout.
- Store: is_str_op=1, md=0xFFFF_FFF0, rd_val=0x1234_5678, immediate ack -> mem_we=1, mem_wdata=0x12345678, addr=0xFFFFFFF0; no reg_we, cpsr_we or pc_we; one retired pulse.
- Compare/jump pair: cmp with cpsr_in=0x4 -> cpsr_we, cpsr_wval=0x4. Then jmp md=0x100 taken=1 -> pc_we, pc_wval=0x100. Then jmp taken=0 -> no pc_we, retired pulses.
- Timeout: ld with mem_ack never asserted, ACK_TIMEOUT=15 -> mem_req high 15 cycles then low; mem_err=1 and stays 1 after later instructions; no reg_we; retired pulses once.
- Reset mid-MEM: rst_n low 1 cycle during an outstanding ld -> next cycle mem_req=0, mem_err=0, no reg_we, in_ready=1; a late mem_ack arriving afterwards causes no strobe.
